// File: rtl/pipeline_pkg.sv
// Constants shared by the elastic pipeline and its stages.
package pipeline_pkg;

  localparam int MODE_PASS = 0;
  localparam int MODE_INC  = 1;

endpackage

// File: rtl/pipeline_stage.sv
// One elastic pipeline slot: a valid bit plus a data register, optionally
// adding INC to whatever it loads.
module pipeline_stage
  import pipeline_pkg::*;
#(
  parameter int              WIDTH = 8,
  parameter int              MODE  = MODE_INC,
  parameter logic [WIDTH-1:0] INC  = WIDTH'(1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             load,
  input  logic             empty,
  input  logic [WIDTH-1:0] data_src,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic [WIDTH-1:0] data_next;

  assign data_next = (MODE == MODE_INC) ? data_src + INC : data_src;

  // A load while emptying keeps the slot full, so load takes priority over empty.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      data  <= data_next;
    end else if (empty) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/elastic_pipeline.sv
// DEPTH-stage elastic pipeline with DIR/ack producer side, DOR/ack consumer
// side, bubble collapse, flush and a registered occupancy count.
module elastic_pipeline
  import pipeline_pkg::*;
#(
  parameter int               WIDTH = 8,
  parameter int               DEPTH = 4,
  parameter int               MODE  = MODE_INC,
  parameter logic [WIDTH-1:0] INC   = WIDTH'(1)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       dir,
  output logic                       ack_out,
  input  logic [WIDTH-1:0]           data_in,
  output logic                       dor,
  input  logic                       ack_in,
  output logic [WIDTH-1:0]           data_out,
  input  logic                       flush,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int OCC_W = $clog2(DEPTH+1);

  logic [DEPTH-1:0] stage_valid;
  logic [DEPTH-1:0] stage_load;
  logic [DEPTH-1:0] stage_empty;
  logic [WIDTH-1:0] stage_data [DEPTH];
  logic             consume;
  logic             accept;

  assign consume = ack_in & stage_valid[DEPTH-1];

  // Resolve moves from the output backwards so a stage can refill on the
  // same edge its occupant moves on.
  always_comb begin
    stage_load  = '0;
    stage_empty = '0;
    stage_empty[DEPTH-1] = consume;
    for (int i = DEPTH - 2; i >= 0; i--) begin
      stage_load[i+1] = stage_valid[i] & (~stage_valid[i+1] | stage_empty[i+1]);
      stage_empty[i]  = stage_load[i+1];
    end
    accept        = dir & ~ack_out & ~flush & (~stage_valid[0] | stage_empty[0]);
    stage_load[0] = accept;
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    logic [WIDTH-1:0] src;
    if (i == 0) begin : g_first
      assign src = data_in;
    end else begin : g_rest
      assign src = stage_data[i-1];
    end

    pipeline_stage #(
      .WIDTH (WIDTH),
      .MODE  (MODE),
      .INC   (INC)
    ) u_stage (
      .clk      (clk),
      .reset    (reset),
      .clear    (flush),
      .load     (stage_load[i]),
      .empty    (stage_empty[i]),
      .data_src (src),
      .valid    (stage_valid[i]),
      .data     (stage_data[i])
    );
  end

  // ack_out pulses for exactly the cycle after an accept, which also blocks
  // the next accept and caps input rate at one item per two cycles.
  always_ff @(posedge clk) begin
    if (!reset) begin
      ack_out   <= 1'b0;
      occupancy <= '0;
    end else if (flush) begin
      ack_out   <= 1'b0;
      occupancy <= '0;
    end else begin
      ack_out   <= accept;
      occupancy <= occupancy + OCC_W'(accept) - OCC_W'(consume);
    end
  end

  assign dor      = stage_valid[DEPTH-1];
  assign data_out = stage_data[DEPTH-1];

endmodule

// File: tb/tb_elastic_pipeline.sv
// Directed bench for elastic_pipeline: a queue-based model checked every
// cycle, plus literal checks on the main, pass-through and single-stage builds.
module tb_elastic_pipeline;

  localparam int W = 8;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         dir = 1'b0, ack_in = 1'b0, flush = 1'b0;
  logic [W-1:0] data_in = '0;
  logic         ack_out, dor;
  logic [W-1:0] data_out;
  logic [2:0]   occupancy;

  logic         p_dir = 1'b0, p_ack_in = 1'b0;
  logic [W-1:0] p_data_in = '0;
  logic         p_ack_out, p_dor;
  logic [W-1:0] p_data_out;
  logic [2:0]   p_occ;

  logic         s_dir = 1'b0, s_ack_in = 1'b0;
  logic [W-1:0] s_data_in = '0;
  logic         s_ack_out, s_dor;
  logic [W-1:0] s_data_out;
  logic [0:0]   s_occ;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  elastic_pipeline #(.WIDTH(W), .DEPTH(D), .MODE(1), .INC(8'd1)) dut (
    .clk(clk), .reset(reset), .dir(dir), .ack_out(ack_out), .data_in(data_in),
    .dor(dor), .ack_in(ack_in), .data_out(data_out), .flush(flush),
    .occupancy(occupancy)
  );

  elastic_pipeline #(.WIDTH(W), .DEPTH(D), .MODE(0), .INC(8'd1)) dut_pass (
    .clk(clk), .reset(reset), .dir(p_dir), .ack_out(p_ack_out), .data_in(p_data_in),
    .dor(p_dor), .ack_in(p_ack_in), .data_out(p_data_out), .flush(1'b0),
    .occupancy(p_occ)
  );

  elastic_pipeline #(.WIDTH(W), .DEPTH(1), .MODE(1), .INC(8'd1)) dut_single (
    .clk(clk), .reset(reset), .dir(s_dir), .ack_out(s_ack_out), .data_in(s_data_in),
    .dor(s_dor), .ack_in(s_ack_in), .data_out(s_data_out), .flush(1'b0),
    .occupancy(s_occ)
  );

  // Model: ordered list of items with their slot index; each edge the oldest
  // may leave, every item advances one slot if the slot ahead is free.
  typedef struct {
    logic [W-1:0] d;
    int           pos;
  } item_t;

  item_t q[$];
  item_t nq[$];
  item_t it;
  logic  m_ack = 1'b0;
  bit    checking = 0;
  int    limit;
  bit    acc;

  always @(posedge clk) begin
    if (!reset || flush) begin
      q.delete();
      m_ack = 1'b0;
      if (!reset) checking = 1;
    end else begin
      nq.delete();
      limit = D - 1;
      foreach (q[i]) begin
        it = q[i];
        if (!(i == 0 && ack_in && it.pos == D - 1)) begin
          if (it.pos < limit) begin
            it.pos = it.pos + 1;
            it.d   = it.d + 8'd1;
          end
          limit = it.pos - 1;
          nq.push_back(it);
        end
      end
      acc = dir && !m_ack && (limit >= 0);
      if (acc) begin
        it.d   = data_in + 8'd1;
        it.pos = 0;
        nq.push_back(it);
      end
      m_ack = acc;
      q = nq;
    end
  end

  logic         exp_dor;
  logic [W-1:0] exp_data;

  always @(negedge clk) begin
    if (checking) begin
      exp_dor  = (q.size() > 0) && (q[0].pos == D - 1);
      exp_data = (q.size() > 0) ? q[0].d : 8'd0;
      vectors++;
      if (dor !== exp_dor || ack_out !== m_ack || occupancy !== 3'(q.size()) ||
          (exp_dor && data_out !== exp_data)) begin
        miscompares++;
        $display("[TB] FAIL model_cmp t=%0t got dor=%b ack=%b occ=%0d data=%0d want dor=%b ack=%b occ=%0d data=%0d",
                 $time, dor, ack_out, occupancy, data_out, exp_dor, m_ack, q.size(), exp_data);
      end
    end
  end

  task automatic check_val(input string name, input logic [31:0] act, input int exp);
    vectors++;
    if (act !== 32'(exp)) begin
      miscompares++;
      $display("[TB] FAIL %s got %0d want %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
    if (ack_out) dir = 1'b0;
  endtask

  task automatic push(input logic [W-1:0] v);
    dir = 1'b1;
    data_in = v;
    for (int n = 0; n < 30; n++) begin
      tick();
      if (ack_out) break;
    end
    check_val("push_ack", ack_out, 1);
    dir = 1'b0;
  endtask

  task automatic wait_dor();
    for (int n = 0; n < 30 && !dor; n++) tick();
    check_val("dor_wait", dor, 1);
  endtask

  task automatic take(input int exp);
    wait_dor();
    check_val("take_data", data_out, exp);
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
  endtask

  int ack_times[$];
  int idx, recv, max_occ;

  initial begin
    tick();
    tick();
    check_val("rst_dor", dor, 0);
    check_val("rst_occ", occupancy, 0);
    check_val("rst_ack", ack_out, 0);
    check_val("rst_data", data_out, 0);
    reset = 1'b1;
    tick();

    // Single item latency and increment
    dir = 1'b1;
    data_in = 8'd42;
    tick();
    check_val("t1_ack_pulse", ack_out, 1);
    check_val("t1_dor_e0", dor, 0);
    dir = 1'b0;
    tick();
    check_val("t1_ack_drop", ack_out, 0);
    check_val("t1_dor_e1", dor, 0);
    tick();
    check_val("t1_dor_e2", dor, 0);
    tick();
    check_val("t1_dor_e3", dor, 1);
    check_val("t1_data", data_out, 46);
    check_val("t1_occ", occupancy, 1);
    ack_in = 1'b1;
    tick();
    ack_in = 1'b0;
    check_val("t1_dor_after", dor, 0);
    check_val("t1_occ_after", occupancy, 0);

    // Wrap-around
    push(8'd253);
    take(1);

    // Backpressure
    push(8'd10);
    push(8'd20);
    push(8'd30);
    push(8'd40);
    dir = 1'b1;
    data_in = 8'd50;
    for (int n = 0; n < 6; n++) begin
      tick();
      check_val("bp_no_ack", ack_out, 0);
    end
    check_val("bp_occ", occupancy, 4);
    check_val("bp_dir_held", dir, 1);
    for (int k = 0; k < 5; k++) take(14 + 10 * k);
    check_val("bp_empty", occupancy, 0);

    // Streaming
    idx = 0; recv = 0; max_occ = 0;
    ack_times.delete();
    dir = 1'b1;
    data_in = 8'd100;
    for (int t = 0; t < 60 && recv < 6; t++) begin
      tick();
      if (ack_out) begin
        ack_times.push_back(t);
        idx++;
        if (idx < 6) begin
          dir = 1'b1;
          data_in = 8'(100 + 10 * idx);
        end
      end
      if (int'(occupancy) > max_occ) max_occ = int'(occupancy);
      if (dor) begin
        check_val("stream_data", data_out, 104 + 10 * recv);
        recv++;
        ack_in = 1'b1;
      end else begin
        ack_in = 1'b0;
      end
    end
    tick();
    ack_in = 1'b0;
    dir = 1'b0;
    check_val("stream_recv", recv, 6);
    check_val("stream_maxocc_le2", max_occ <= 2, 1);
    check_val("stream_accepts", ack_times.size(), 6);
    if (ack_times.size() == 6)
      check_val("stream_rate", ack_times[5] - ack_times[0], 10);

    // Flush with items and a pending dir
    push(8'd1);
    push(8'd2);
    push(8'd3);
    dir = 1'b1;
    data_in = 8'd99;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    dir = 1'b0;
    check_val("fl_dor", dor, 0);
    check_val("fl_occ", occupancy, 0);
    check_val("fl_ack", ack_out, 0);
    tick();
    check_val("fl_ack_next", ack_out, 0);
    push(8'd7);
    take(11);
    check_val("fl_occ_end", occupancy, 0);

    // Reset mid-stream
    push(8'd5);
    push(8'd6);
    reset = 1'b0;
    tick();
    check_val("mr_dor", dor, 0);
    check_val("mr_occ", occupancy, 0);
    check_val("mr_ack", ack_out, 0);
    check_val("mr_data", data_out, 0);
    reset = 1'b1;
    tick();

    // Pass-through build
    p_dir = 1'b1;
    p_data_in = 8'd253;
    tick();
    check_val("pass_ack", p_ack_out, 1);
    p_dir = 1'b0;
    tick();
    tick();
    tick();
    check_val("pass_dor", p_dor, 1);
    check_val("pass_data", p_data_out, 253);
    p_ack_in = 1'b1;
    tick();
    p_ack_in = 1'b0;
    check_val("pass_dor_after", p_dor, 0);

    // Single-stage build
    s_dir = 1'b1;
    s_data_in = 8'd42;
    tick();
    s_dir = 1'b0;
    check_val("single_ack", s_ack_out, 1);
    check_val("single_dor", s_dor, 1);
    check_val("single_data", s_data_out, 43);
    check_val("single_occ", s_occ, 1);
    s_ack_in = 1'b1;
    tick();
    s_ack_in = 1'b0;
    check_val("single_dor_after", s_dor, 0);

    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
